// File: rtl/sram_bank_array.sv
// Dual-port OBI front end for NUM_BANKS 1rw1r SRAM macros: data port on macro port 0, instruction port on port 1.
// Optional access/hazard counters are enabled with `define SRAM_PERF_CNT_EN.

// Behavioural stand-in for the sky130_sram_2kbyte_1rw1r_32x512_8 macro: active-low selects, registered dout.
module sram_bank_array_macro #(
  parameter int WORDS  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              clk0,
  input  logic              csb0,
  input  logic              web0,
  input  logic [3:0]        wmask0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       din0,
  output logic [31:0]       dout0,
  input  logic              clk1,
  input  logic              csb1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [31:0]       dout1
);

  logic [31:0] mem [WORDS];

  // NOTE: storage arrays and macro output latches are never reset; real SRAM has no reset and
  // a reset term would turn the array into flops.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int k = 0; k < 4; k++) begin
          if (wmask0[k]) mem[addr0][8*k +: 8] <= din0[8*k +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

module sram_bank_array #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          NUM_BANKS  = 3,
  parameter int          BANK_WORDS = 512,
  parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        d_req_i,
  output logic        d_gnt_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic        d_err_o,
  output logic [31:0] d_rdata_o,
  input  logic        i_req_i,
  output logic        i_gnt_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_we_i,
  output logic        i_rvalid_o,
  output logic        i_err_o,
  output logic [31:0] i_rdata_o,
  output logic        illegal_o
`ifdef SRAM_PERF_CNT_EN
  ,
  output logic [31:0] d_acc_cnt_o,
  output logic [31:0] i_acc_cnt_o,
  output logic [31:0] hazard_cnt_o
`endif
);

  localparam int          WADDR_W  = $clog2(BANK_WORDS);
  localparam int          BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  // 33 bits so an array ending exactly at 4 GiB does not wrap to zero.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(NUM_BANKS * BANK_WORDS * 4);

  function automatic logic addr_legal(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  logic               d_legal, i_legal;
  logic [BANK_W-1:0]  d_bank, i_bank;
  logic [WADDR_W-1:0] d_word, i_word;
  logic               hazard;
  logic               d_acc, i_acc, d_bad, i_bad;

  assign d_legal = addr_legal(d_addr_i);
  assign i_legal = addr_legal(i_addr_i);
  assign d_bank  = d_addr_i[WADDR_W+2 +: BANK_W];
  assign i_bank  = i_addr_i[WADDR_W+2 +: BANK_W];
  assign d_word  = d_addr_i[2 +: WADDR_W];
  assign i_word  = i_addr_i[2 +: WADDR_W];

  // A d write to the word the i port wants to read in the same cycle wins; i retries next cycle.
  assign hazard  = d_req_i & d_we_i & d_legal & i_legal & (d_bank == i_bank) & (d_word == i_word);

  assign d_gnt_o = d_req_i;
  assign i_gnt_o = i_req_i & ~hazard;

  assign d_acc   = d_req_i & d_legal;
  assign i_acc   = i_gnt_o & i_legal & ~i_we_i;
  assign d_bad   = d_req_i & ~d_legal;
  assign i_bad   = i_gnt_o & ~(i_legal & ~i_we_i);

  logic [NUM_BANKS-1:0] d_bank_oh, i_bank_oh;
  logic [NUM_BANKS-1:0] d_csb, i_csb;

  // NOTE: every always_comb output gets a default before the loop so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    d_bank_oh = '0;
    i_bank_oh = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      d_bank_oh[b] = (d_bank == BANK_W'(b));
      i_bank_oh[b] = (i_bank == BANK_W'(b));
    end
    d_csb = ~(d_bank_oh & {NUM_BANKS{d_acc}});
    i_csb = ~(i_bank_oh & {NUM_BANKS{i_acc}});
  end

  logic [31:0] d_dout [NUM_BANKS];
  logic [31:0] i_dout [NUM_BANKS];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sram_bank_array_macro #(
      .WORDS  (BANK_WORDS),
      .ADDR_W (WADDR_W)
    ) u_macro (
      .clk0   (clk_i),
      .csb0   (d_csb[g]),
      .web0   (~d_we_i),
      .wmask0 (d_be_i),
      .addr0  (d_word),
      .din0   (d_wdata_i),
      .dout0  (d_dout[g]),
      .clk1   (clk_i),
      .csb1   (i_csb[g]),
      .addr1  (i_word),
      .dout1  (i_dout[g])
    );
  end

  // One-deep response registers per port; bank select is only set for reads so idle rdata is zero.
  logic                 d_rvalid_q, d_err_q, d_wr_q;
  logic                 i_rvalid_q, i_err_q;
  logic [NUM_BANKS-1:0] d_sel_q, i_sel_q;
  logic                 illegal_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_wr_q     <= 1'b0;
      d_sel_q    <= '0;
      i_rvalid_q <= 1'b0;
      i_err_q    <= 1'b0;
      i_sel_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      d_rvalid_q <= d_gnt_o;
      d_err_q    <= d_bad;
      d_wr_q     <= d_acc & d_we_i;
      d_sel_q    <= (d_acc & ~d_we_i) ? d_bank_oh : '0;
      i_rvalid_q <= i_gnt_o;
      i_err_q    <= i_bad;
      i_sel_q    <= i_acc ? i_bank_oh : '0;
      illegal_q  <= d_bad | i_bad;
    end
  end

  logic [31:0] d_rd_mux, i_rd_mux;

  always_comb begin
    d_rd_mux = '0;
    i_rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      d_rd_mux = d_rd_mux | (d_dout[b] & {32{d_sel_q[b]}});
      i_rd_mux = i_rd_mux | (i_dout[b] & {32{i_sel_q[b]}});
    end
  end

  assign d_rvalid_o = d_rvalid_q;
  assign d_err_o    = d_err_q;
  assign d_rdata_o  = d_err_q ? ERR_RDATA : (d_wr_q ? 32'h0 : d_rd_mux);
  assign i_rvalid_o = i_rvalid_q;
  assign i_err_o    = i_err_q;
  assign i_rdata_o  = i_err_q ? ERR_RDATA : i_rd_mux;
  assign illegal_o  = illegal_q;

`ifdef SRAM_PERF_CNT_EN
  logic [31:0] d_acc_cnt_q, i_acc_cnt_q, hazard_cnt_q;

  // Free-running counters; 32-bit addition wraps to zero on overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_acc_cnt_q  <= '0;
      i_acc_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      if (d_acc)  d_acc_cnt_q  <= d_acc_cnt_q + 32'd1;
      if (i_acc)  i_acc_cnt_q  <= i_acc_cnt_q + 32'd1;
      if (hazard) hazard_cnt_q <= hazard_cnt_q + 32'd1;
    end
  end

  assign d_acc_cnt_o  = d_acc_cnt_q;
  assign i_acc_cnt_o  = i_acc_cnt_q;
  assign hazard_cnt_o = hazard_cnt_q;
`endif

endmodule

// File: tb/tb_sram_bank_array.sv
// Self-checking bench for sram_bank_array: directed vector table, reset corner cases and
// randomized traffic scored against a flat word-array model of the whole address space.
module tb_sram_bank_array;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          NB   = 3;
  localparam int          BW   = 512;
  localparam int          NW   = NB * BW;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
  localparam logic [31:0] ENDA = BASE + NW * 4;

  logic        clk_i, rst_i;
  logic        d_req_i, d_gnt_o, d_we_i, d_rvalid_o, d_err_o;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]  d_be_i;
  logic        i_req_i, i_gnt_o, i_we_i, i_rvalid_o, i_err_o, illegal_o;
  logic [31:0] i_addr_i, i_rdata_o;
`ifdef SRAM_PERF_CNT_EN
  logic [31:0] d_acc_cnt_o, i_acc_cnt_o, hazard_cnt_o;
`endif

  sram_bank_array #(
    .BASE_ADDR  (BASE),
    .NUM_BANKS  (NB),
    .BANK_WORDS (BW),
    .ERR_RDATA  (ERR)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .d_req_i    (d_req_i),
    .d_gnt_o    (d_gnt_o),
    .d_addr_i   (d_addr_i),
    .d_we_i     (d_we_i),
    .d_be_i     (d_be_i),
    .d_wdata_i  (d_wdata_i),
    .d_rvalid_o (d_rvalid_o),
    .d_err_o    (d_err_o),
    .d_rdata_o  (d_rdata_o),
    .i_req_i    (i_req_i),
    .i_gnt_o    (i_gnt_o),
    .i_addr_i   (i_addr_i),
    .i_we_i     (i_we_i),
    .i_rvalid_o (i_rvalid_o),
    .i_err_o    (i_err_o),
    .i_rdata_o  (i_rdata_o),
    .illegal_o  (illegal_o)
`ifdef SRAM_PERF_CNT_EN
    ,
    .d_acc_cnt_o  (d_acc_cnt_o),
    .i_acc_cnt_o  (i_acc_cnt_o),
    .hazard_cnt_o (hazard_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: one flat word array covering the whole legal byte range.
  logic [31:0] mem [NW];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_d_acc = 0, m_i_acc = 0, m_haz = 0;

  logic        cap_i_gnt, cap_d_err, cap_i_err;
  logic [31:0] cap_d_rdata, cap_i_rdata;

  function automatic bit legal(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + longint'(NW) * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] pat(input int i);
    return {16'(i) ^ 16'h5A5A, 16'(i * 7)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, check grants, advance the model, then check the registered responses.
  task automatic step(input logic dr, input logic [31:0] da, input logic dw, input logic [3:0] be,
                      input logic [31:0] wd, input logic ir, input logic [31:0] ia, input logic iw);
    bit          dl, il, haz, eig, ed_err, ei_err;
    logic [31:0] ed_rd, ei_rd;
    d_req_i = dr; d_addr_i = da; d_we_i = dw; d_be_i = be; d_wdata_i = wd;
    i_req_i = ir; i_addr_i = ia; i_we_i = iw;
    #1;
    dl  = legal(da);
    il  = legal(ia);
    haz = dr && dw && dl && il && (widx(da) == widx(ia));
    eig = ir && !haz;
    check("d_gnt", d_gnt_o, dr);
    check("i_gnt", i_gnt_o, eig);
    cap_i_gnt = i_gnt_o;
    ed_err = dr && !dl;
    ed_rd  = 32'h0;
    if (ed_err) ed_rd = ERR;
    else if (dr && !dw) ed_rd = mem[widx(da)];
    ei_err = eig && (!il || iw);
    ei_rd  = 32'h0;
    if (ei_err) ei_rd = ERR;
    else if (eig) ei_rd = mem[widx(ia)];
    if (dr && dl && dw)
      for (int k = 0; k < 4; k++) if (be[k]) mem[widx(da)][8*k +: 8] = wd[8*k +: 8];
    if (dr && dl) m_d_acc++;
    if (eig && il && !iw) m_i_acc++;
    if (haz) m_haz++;
    @(posedge clk_i);
    #1;
    check("d_rvalid", d_rvalid_o, dr);
    if (dr) begin
      check("d_err", d_err_o, ed_err);
      check("d_rdata", d_rdata_o, ed_rd);
    end
    check("i_rvalid", i_rvalid_o, eig);
    if (eig) begin
      check("i_err", i_err_o, ei_err);
      check("i_rdata", i_rdata_o, ei_rd);
    end
    check("illegal", illegal_o, ed_err || ei_err);
    cap_d_err = d_err_o; cap_d_rdata = d_rdata_o;
    cap_i_err = i_err_o; cap_i_rdata = i_rdata_o;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
    if (r == 1) return ENDA + 32'(4 * $urandom_range(0, 3));
    return BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
  endfunction

  typedef struct {
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_we;
    logic        exp_i_gnt;
    logic        exp_d_err;
    logic [31:0] exp_d_rdata;
    logic        exp_i_err;
    logic [31:0] exp_i_rdata;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic        hold;
    logic        rd, rw, ri, riw;
    logic [31:0] ra, rwd, ria;
    logic [3:0]  rbe;

    rst_i = 1'b1;
    d_req_i = 0; d_addr_i = 0; d_we_i = 0; d_be_i = 0; d_wdata_i = 0;
    i_req_i = 0; i_addr_i = 0; i_we_i = 0;
    for (int w = 0; w < NW; w++) mem[w] = 32'h0;
    #12;
    check("rst_d_rvalid", d_rvalid_o, 1'b0);
    check("rst_i_rvalid", i_rvalid_o, 1'b0);
    check("rst_d_rdata", d_rdata_o, 32'h0);
    check("rst_i_rdata", i_rdata_o, 32'h0);
    check("rst_illegal", illegal_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Fill every word so later reads never see uninitialised storage.
    for (int w = 0; w < NW; w++)
      step(1'b1, BASE + 32'(w * 4), 1'b1, 4'hF, pat(w), 1'b0, 32'h0, 1'b0);

    //            dreq  d_addr            dwe   be     wdata          ireq  i_addr            iwe   igt  derr  d_rdata        ierr  i_rdata
    vecs.push_back('{1'b1, 32'h8000_0804, 1'b1, 4'hF, 32'hA5A5_1234, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h8000_0804, 1'b0, 4'hF, 32'h0,         1'b1, 32'h8000_0804, 1'b0, 1'b1, 1'b0, 32'hA5A5_1234, 1'b0, 32'hA5A5_1234});
    vecs.push_back('{1'b1, 32'h8000_0010, 1'b1, 4'hF, 32'hCAFE_0001, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,         1'b0, 4'h0, 32'h0,         1'b1, 32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'hCAFE_0001});
    vecs.push_back('{1'b1, 32'h8000_1800, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0,         1'b0, 4'h0, 32'h0,         1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h8000_17FC, 1'b1, 4'hF, 32'h1111_1111, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h8000_17FC, 1'b1, 4'h4, 32'h00FF_0000, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h8000_17FC, 1'b0, 4'hF, 32'h0,         1'b1, 32'h8000_0806, 1'b0, 1'b1, 1'b0, 32'h11FF_1111, 1'b0, 32'hA5A5_1234});
    vecs.push_back('{1'b1, 32'h7FFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 32'h8000_17FC, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h11FF_1111});
    vecs.push_back('{1'b1, 32'h8000_1000, 1'b1, 4'hF, 32'h7777_0000, 1'b1, 32'h8000_0FFC, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, pat(1023)});
    vecs.push_back('{1'b0, 32'h0,         1'b0, 4'h0, 32'h0,         1'b1, 32'h8000_1000, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h7777_0000});

    foreach (vecs[n]) begin
      step(vecs[n].d_req, vecs[n].d_addr, vecs[n].d_we, vecs[n].d_be, vecs[n].d_wdata,
           vecs[n].i_req, vecs[n].i_addr, vecs[n].i_we);
      check($sformatf("vec%0d_i_gnt", n), cap_i_gnt, vecs[n].exp_i_gnt);
      if (vecs[n].d_req) begin
        check($sformatf("vec%0d_d_err", n), cap_d_err, vecs[n].exp_d_err);
        check($sformatf("vec%0d_d_rdata", n), cap_d_rdata, vecs[n].exp_d_rdata);
      end
      if (vecs[n].exp_i_gnt) begin
        check($sformatf("vec%0d_i_err", n), cap_i_err, vecs[n].exp_i_err);
        check($sformatf("vec%0d_i_rdata", n), cap_i_rdata, vecs[n].exp_i_rdata);
      end
    end
    idle();

    // Async reset while an error response and a read response are pending.
    d_req_i = 1'b1; d_addr_i = ENDA; d_we_i = 1'b0;
    i_req_i = 1'b1; i_addr_i = 32'h8000_0804; i_we_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("pre_rst_d_rvalid", d_rvalid_o, 1'b1);
    check("pre_rst_illegal", illegal_o, 1'b1);
    #1;
    rst_i = 1'b1;
    #1;
    check("mid_rst_d_rvalid", d_rvalid_o, 1'b0);
    check("mid_rst_i_rvalid", i_rvalid_o, 1'b0);
    check("mid_rst_d_rdata", d_rdata_o, 32'h0);
    check("mid_rst_i_rdata", i_rdata_o, 32'h0);
    check("mid_rst_illegal", illegal_o, 1'b0);
    d_req_i = 1'b0; i_req_i = 1'b0;
    m_d_acc = 0; m_i_acc = 0; m_haz = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst_i_rvalid", i_rvalid_o, 1'b0);
    // Storage survives reset.
    step(1'b1, 32'h8000_0804, 1'b0, 4'hF, 32'h0, 1'b1, 32'h8000_17FC, 1'b0);
    check("retain_d", cap_d_rdata, 32'hA5A5_1234);
    check("retain_i", cap_i_rdata, 32'h11FF_1111);

    // Randomized traffic; a stalled i request holds its address until granted.
    hold = 1'b0;
    ri = 1'b0; ria = 32'h0; riw = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rd  = ($urandom_range(0, 3) != 0);
      rw  = $urandom_range(0, 1) == 1;
      ra  = rand_addr();
      rbe = 4'($urandom);
      rwd = $urandom;
      if (!hold) begin
        ri  = ($urandom_range(0, 2) != 0);
        ria = ($urandom_range(0, 2) == 0) ? (ra ^ 32'($urandom_range(0, 3))) : rand_addr();
        riw = ($urandom_range(0, 15) == 0);
      end
      step(rd, ra, rw, rbe, rwd, ri, ria, riw);
      hold = ri && !cap_i_gnt;
    end
    idle();

`ifdef SRAM_PERF_CNT_EN
    check("d_acc_cnt", d_acc_cnt_o, m_d_acc);
    check("i_acc_cnt", i_acc_cnt_o, m_i_acc);
    check("hazard_cnt", hazard_cnt_o, m_haz);
    rst_i = 1'b1;
    #2;
    m_d_acc = 0; m_i_acc = 0; m_haz = 0;
    check("cnt_rst", d_acc_cnt_o | i_acc_cnt_o | hazard_cnt_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int h = 0; h < 2; h++) begin
      step(1'b1, 32'h8000_0020, 1'b1, 4'hF, 32'(h), 1'b1, 32'h8000_0020, 1'b0);
      step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 32'h8000_0020, 1'b0);
    end
    for (int k = 0; k < 8; k++)
      step(1'b1, BASE + 32'(k * 256), 1'b0, 4'hF, 32'h0, (k < 3), BASE + 32'(k * 4), 1'b0);
    idle();
    check("d_acc_cnt_10", d_acc_cnt_o, 32'd10);
    check("i_acc_cnt_5", i_acc_cnt_o, 32'd5);
    check("hazard_cnt_2", hazard_cnt_o, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
